// File: rtl/rx_frame_reader.sv
// rx_frame_reader: read-side sequencer for the UART receive async FIFO (rclk domain).
// Hunts for a SYNC byte, then parses LEN, payload and CHK. Payload bytes leave on a
// one-entry valid/ready output register. Every frame ends with a single frm_done pulse
// carrying its status: ok, bad checksum, bad length or timeout.
module rx_frame_reader #(
  parameter int                  DATASIZE = 8,
  parameter logic [DATASIZE-1:0] SYNC     = 8'hA5,
  parameter int                  MAX_LEN  = 16,
  parameter int                  TIMEOUT  = 1000
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [DATASIZE-1:0] fifo_rdata,
  input  logic                fifo_rempty,
  output logic                fifo_rinc,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                frm_done,
  output logic [1:0]          frm_status
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATASIZE-1:0] MAX_LEN_B = DATASIZE'(MAX_LEN);
  localparam logic [DATASIZE-1:0] ZERO_B    = {DATASIZE{1'b0}};
  localparam logic [CW-1:0]       CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]       CNT_ZERO  = {CW{1'b0}};
  localparam logic [TW-1:0]       TCNT_ONE  = TW'(1);
  localparam logic [TW-1:0]       TCNT_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]       TCNT_MAX  = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BAD_CHK = 2'b01;
  localparam logic [1:0] ST_BAD_LEN = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_LEN  = 2'd1,
    S_PAY  = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  // Running checksum: plain XOR over LEN and payload bytes.
  function automatic logic [DATASIZE-1:0] chk_update(input logic [DATASIZE-1:0] acc,
                                                     input logic [DATASIZE-1:0] b);
    return acc ^ b;
  endfunction

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [DATASIZE-1:0] chk_r, chk_s;
  logic [TW-1:0]       tcnt_r, tcnt_s;
  logic [DATASIZE-1:0] m_data_r, m_data_s;
  logic                m_valid_r, m_valid_s;
  logic                m_last_r, m_last_s;
  logic                frm_done_r, frm_done_s;
  logic [1:0]          frm_status_r, frm_status_s;
  logic                consume_s;
  logic                pop_s;
  logic                timeout_s;

  // Willingness to pop: payload only moves when the output register is free or draining.
  always_comb begin
    consume_s = 1'b1;
    case (state_r)
      S_HUNT:  consume_s = 1'b1;
      S_LEN:   consume_s = 1'b1;
      S_PAY:   consume_s = !m_valid_r || m_ready;
      S_CHK:   consume_s = 1'b1;
      default: consume_s = 1'b1;
    endcase
  end

  assign pop_s     = consume_s & ~fifo_rempty;
  assign fifo_rinc = pop_s;

  // Next-state, counters, checksum and output-register updates.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    chk_s        = chk_r;
    tcnt_s       = tcnt_r;
    m_data_s     = m_data_r;
    m_valid_s    = m_valid_r;
    m_last_s     = m_last_r;
    frm_done_s   = 1'b0;
    frm_status_s = frm_status_r;
    timeout_s    = 1'b0;

    // A pending byte drains on handshake in any state; a new pop below overrides this.
    if (m_valid_r && m_ready) begin
      m_valid_s = 1'b0;
      m_last_s  = 1'b0;
    end else begin
      m_valid_s = m_valid_r;
    end

    // Starvation timer runs only inside a frame; stalls with data present do not count.
    if (state_r == S_HUNT) begin
      tcnt_s = TCNT_ZERO;
    end else if (pop_s) begin
      tcnt_s = TCNT_ZERO;
    end else if (fifo_rempty) begin
      if (tcnt_r == TCNT_MAX) begin
        timeout_s = 1'b1;
        tcnt_s    = TCNT_ZERO;
      end else begin
        tcnt_s = tcnt_r + TCNT_ONE;
      end
    end else begin
      tcnt_s = tcnt_r;
    end

    case (state_r)
      S_HUNT: begin
        cnt_s = CNT_ZERO;
        chk_s = ZERO_B;
        if (pop_s && (fifo_rdata == SYNC)) begin
          state_s = S_LEN;
        end else begin
          state_s = S_HUNT;
        end
      end
      S_LEN: begin
        if (timeout_s) begin
          frm_done_s   = 1'b1;
          frm_status_s = ST_TIMEOUT;
          state_s      = S_HUNT;
        end else if (pop_s) begin
          if ((fifo_rdata == ZERO_B) || (fifo_rdata > MAX_LEN_B)) begin
            frm_done_s   = 1'b1;
            frm_status_s = ST_BAD_LEN;
            state_s      = S_HUNT;
          end else begin
            cnt_s   = CW'(fifo_rdata);
            chk_s   = fifo_rdata;
            state_s = S_PAY;
          end
        end else begin
          state_s = S_LEN;
        end
      end
      S_PAY: begin
        if (timeout_s) begin
          frm_done_s   = 1'b1;
          frm_status_s = ST_TIMEOUT;
          state_s      = S_HUNT;
        end else if (pop_s) begin
          m_data_s  = fifo_rdata;
          m_valid_s = 1'b1;
          m_last_s  = (cnt_r == CNT_ONE);
          chk_s     = chk_update(chk_r, fifo_rdata);
          cnt_s     = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_s = S_CHK;
          end else begin
            state_s = S_PAY;
          end
        end else begin
          state_s = S_PAY;
        end
      end
      S_CHK: begin
        if (timeout_s) begin
          frm_done_s   = 1'b1;
          frm_status_s = ST_TIMEOUT;
          state_s      = S_HUNT;
        end else if (pop_s) begin
          frm_done_s   = 1'b1;
          frm_status_s = (fifo_rdata == chk_r) ? ST_OK : ST_BAD_CHK;
          state_s      = S_HUNT;
        end else begin
          state_s = S_CHK;
        end
      end
      default: begin
        state_s = S_HUNT;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_r      <= S_HUNT;
      cnt_r        <= CNT_ZERO;
      chk_r        <= ZERO_B;
      tcnt_r       <= TCNT_ZERO;
      m_data_r     <= ZERO_B;
      m_valid_r    <= 1'b0;
      m_last_r     <= 1'b0;
      frm_done_r   <= 1'b0;
      frm_status_r <= ST_OK;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      chk_r        <= chk_s;
      tcnt_r       <= tcnt_s;
      m_data_r     <= m_data_s;
      m_valid_r    <= m_valid_s;
      m_last_r     <= m_last_s;
      frm_done_r   <= frm_done_s;
      frm_status_r <= frm_status_s;
    end
  end

  assign m_data     = m_data_r;
  assign m_valid    = m_valid_r;
  assign m_last     = m_last_r;
  assign frm_done   = frm_done_r;
  assign frm_status = frm_status_r;

endmodule

// File: tb/tb_rx_frame_reader.sv
// Testbench for rx_frame_reader: a queue models the FWFT FIFO, a scoreboard holds the
// expected payload and frame statuses, and a monitor compares whenever the DUT presents them.
module tb_rx_frame_reader;

  localparam int TIMEOUT = 25;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [7:0] fifo_rdata;
  logic       fifo_rempty;
  logic       fifo_rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       frm_done;
  logic [1:0] frm_status;

  // Free-running read clock.
  always #5 rclk = ~rclk;

  rx_frame_reader #(
    .DATASIZE(8),
    .SYNC    (8'hA5),
    .MAX_LEN (16),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_rdata (fifo_rdata),
    .fifo_rempty(fifo_rempty),
    .fifo_rinc  (fifo_rinc),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .frm_done   (frm_done),
    .frm_status (frm_status)
  );

  logic [7:0] fq[$];
  logic [8:0] exp_q[$];
  logic [1:0] est_q[$];
  int compares = 0;
  int errs = 0;
  int cyc = 0;
  int pops = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  int bad_rinc = 0;
  int p0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compares++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic refresh();
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic pb(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  task automatic ep(input logic [7:0] d, input logic l);
    exp_q.push_back({d, l});
  endtask

  task automatic es(input logic [1:0] s);
    est_q.push_back(s);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (((exp_q.size() + est_q.size()) != 0) && (n < budget)) begin
      step(1);
      n++;
    end
    check("drain_budget", 32'(exp_q.size() + est_q.size()), 32'd0);
    step(3);
  endtask

  task automatic fifo_model();
    logic pn;
    forever begin
      @(negedge rclk);
      pn = fifo_rinc;
      if (fifo_rinc && fifo_rempty) bad_rinc++;
      @(posedge rclk);
      cyc++;
      if (pn) begin
        pops++;
        last_pop_cyc = cyc;
      end
      #1;
      if (pn && (fq.size() > 0)) void'(fq.pop_front());
      refresh();
    end
  endtask

  task automatic monitor();
    logic [8:0] e;
    logic [1:0] s;
    forever begin
      @(negedge rclk);
      if (!rrst) begin
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            compares++;
            errs++;
            $display("FAIL payload_unexpected: got data=%h last=%b, required no payload", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            check("payload", 32'({m_data, m_last}), 32'(e));
          end
        end
        if (frm_done) begin
          done_cyc = cyc;
          if (est_q.size() == 0) begin
            compares++;
            errs++;
            $display("FAIL done_unexpected: got status=%b, required no frm_done", frm_status);
          end else begin
            s = est_q.pop_front();
            check("status", 32'(frm_status), 32'(s));
          end
        end
      end
    end
  endtask

  initial begin
    rrst    = 1'b1;
    m_ready = 1'b1;
    refresh();
    fork
      fifo_model();
      monitor();
    join_none
    step(2);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_frm_done", 32'(frm_done), 32'd0);
    check("rst_frm_status", 32'(frm_status), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_fifo_rinc", 32'(fifo_rinc), 32'd0);
    rrst = 1'b0;
    step(2);

    // Basic frame: payload 11 22 33, CHK 03.
    p0 = pops;
    pb(8'hA5); pb(8'h03); pb(8'h11); pb(8'h22); pb(8'h33); pb(8'h03);
    ep(8'h11, 1'b0); ep(8'h22, 1'b0); ep(8'h33, 1'b1); es(2'b00);
    wait_idle(60);
    check("t1_pops", 32'(pops - p0), 32'd6);

    // Leading garbage discarded while hunting.
    p0 = pops;
    pb(8'h00); pb(8'hFF); pb(8'h5A); pb(8'hA5); pb(8'h02); pb(8'hAA); pb(8'h55); pb(8'hFD);
    ep(8'hAA, 1'b0); ep(8'h55, 1'b1); es(2'b00);
    wait_idle(60);
    check("t2_pops", 32'(pops - p0), 32'd8);

    // Bad checksum: expected 7F, got 00.
    pb(8'hA5); pb(8'h01); pb(8'h7E); pb(8'h00);
    ep(8'h7E, 1'b1); es(2'b01);
    wait_idle(60);

    // Bad lengths 0 and MAX_LEN+1, then well-formed frames.
    pb(8'hA5); pb(8'h00); es(2'b10);
    wait_idle(60);
    pb(8'hA5); pb(8'h11); es(2'b10);
    wait_idle(60);
    pb(8'hA5); pb(8'h01); pb(8'h5A); pb(8'h5B);
    ep(8'h5A, 1'b1); es(2'b00);
    wait_idle(60);
    // LEN = MAX_LEN; payload 00..0F XORs to 00 so CHK = 10.
    pb(8'hA5); pb(8'h10);
    for (int i = 0; i < 16; i++) begin
      pb(8'(i));
      ep(8'(i), (i == 15));
    end
    pb(8'h10); es(2'b00);
    wait_idle(80);

    // Back-pressure stall well beyond TIMEOUT with data present.
    pb(8'hA5); pb(8'h05); pb(8'h01); pb(8'h02);
    ep(8'h01, 1'b0); ep(8'h02, 1'b0); ep(8'h03, 1'b0); ep(8'h04, 1'b0); ep(8'h05, 1'b1);
    es(2'b00);
    step(8);
    m_ready = 1'b0;
    pb(8'h03); pb(8'h04); pb(8'h05); pb(8'h04);
    step(3);
    for (int i = 0; i < 30; i++) begin
      @(negedge rclk);
      check("stall_m_valid", 32'(m_valid), 32'd1);
      check("stall_m_data", 32'(m_data), 32'h03);
      check("stall_fifo_rinc", 32'(fifo_rinc), 32'd0);
    end
    step(1);
    m_ready = 1'b1;
    wait_idle(60);

    // Timeout after a partial payload.
    pb(8'hA5); pb(8'h04); pb(8'h11);
    ep(8'h11, 1'b0); es(2'b11);
    wait_idle(TIMEOUT + 40);
    check("t6_timeout_latency", 32'(done_cyc - last_pop_cyc), 32'(TIMEOUT));

    // Asynchronous reset mid-payload.
    m_ready = 1'b0;
    pb(8'hA5); pb(8'h08); pb(8'h01); pb(8'h02);
    step(5);
    check("pre_rst_m_valid", 32'(m_valid), 32'd1);
    check("pre_rst_m_data", 32'(m_data), 32'h01);
    @(negedge rclk);
    #2;
    rrst = 1'b1;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_data", 32'(m_data), 32'd0);
    check("mid_rst_m_last", 32'(m_last), 32'd0);
    check("mid_rst_frm_done", 32'(frm_done), 32'd0);
    check("mid_rst_frm_status", 32'(frm_status), 32'd0);
    fq.delete();
    refresh();
    step(2);
    rrst = 1'b0;
    m_ready = 1'b1;
    step(2);
    // SYNC bytes inside the payload are plain data.
    pb(8'hA5); pb(8'h02); pb(8'hA5); pb(8'hA5); pb(8'h02);
    ep(8'hA5, 1'b0); ep(8'hA5, 1'b1); es(2'b00);
    wait_idle(60);

    check("scoreboard_left", 32'(exp_q.size() + est_q.size()), 32'd0);
    check("rinc_while_empty", 32'(bad_rinc), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
    $finish;
  end

endmodule
